// File: rtl/lcd_msg_scheduler_pkg.sv
// lcd_msg_scheduler_pkg
//   Shared definitions for the LCD message scheduler: the message code table
//   (also used by LCD_Top and the feeder FSM), scheduler state encoding,
//   default parameter values and a small index-width helper.
package lcd_msg_scheduler_pkg;

  // Default build parameters (50 MHz system clock, 1 s minimum display).
  localparam int N_REQ_DEF    = 4;
  localparam int MSG_W_DEF    = 3;
  localparam int MSG_MAX_DEF  = 5;
  localparam int HOLD_CYC_DEF = 50_000_000;
  localparam int CNT_W_DEF    = 26;

  // LCD message codes.
  localparam logic [2:0] MSG_INICIO    = 3'd0;  // "A:Iniciar / B:Reiniciar"
  localparam logic [2:0] MSG_GATO1     = 3'd1;
  localparam logic [2:0] MSG_GATO2     = 3'd2;
  localparam logic [2:0] MSG_ESPERA    = 3'd3;
  localparam logic [2:0] MSG_SIRVIENDO = 3'd4;
  localparam logic [2:0] MSG_LLENO     = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARB  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lcd_msg_scheduler_if.sv
// lcd_msg_scheduler_if
//   Bundles the requester side and the LCD side of the message scheduler.
//   Signals:
//     iREQ        level request per requester (index 0 = highest priority)
//     iREQ_MSG    code per requester, slice [i*MSG_W +: MSG_W]
//     iLCD_READY  LCD writer idle, may accept a new message
//     oMSG        committed message code for LCD_Top
//     oMSG_STB    one-cycle pulse when oMSG takes a new value
//     oGRANT      one-hot owner of oMSG, zero while the idle message is shown
//     oBUSY       scheduler not in IDLE
//   master: drives requests/ready (requesters + LCD writer); slave: scheduler.
interface lcd_msg_scheduler_if #(
  parameter int N_REQ = 4,
  parameter int MSG_W = 3
);
  logic [N_REQ-1:0]       iREQ;
  logic [N_REQ*MSG_W-1:0] iREQ_MSG;
  logic                   iLCD_READY;
  logic [MSG_W-1:0]       oMSG;
  logic                   oMSG_STB;
  logic [N_REQ-1:0]       oGRANT;
  logic                   oBUSY;

  modport master (
    output iREQ, iREQ_MSG, iLCD_READY,
    input  oMSG, oMSG_STB, oGRANT, oBUSY
  );

  modport slave (
    input  iREQ, iREQ_MSG, iLCD_READY,
    output oMSG, oMSG_STB, oGRANT, oBUSY
  );
endinterface

// File: rtl/lcd_msg_scheduler_prio_arbiter.sv
// lcd_prio_arbiter
//   Combinational fixed-priority pick among the requesters. A requester is
//   eligible when it requests and its code is a valid message (<= MSG_MAX);
//   the lowest eligible index wins.
//   Ports:
//     i_req      request levels
//     i_req_msg  packed per-requester codes
//     o_any      at least one eligible requester
//     o_idx      winner index (0 when none)
//     o_onehot   winner one-hot (0 when none)
//     o_code     winner code (0 when none)
module lcd_prio_arbiter #(
  parameter int N_REQ   = 4,
  parameter int MSG_W   = 3,
  parameter int MSG_MAX = 5,
  parameter int IDX_W   = 2
) (
  input  logic [N_REQ-1:0]       i_req,
  input  logic [N_REQ*MSG_W-1:0] i_req_msg,
  output logic                   o_any,
  output logic [IDX_W-1:0]       o_idx,
  output logic [N_REQ-1:0]       o_onehot,
  output logic [MSG_W-1:0]       o_code
);

  localparam logic [MSG_W-1:0] LP_MSG_MAX = MSG_W'(MSG_MAX);

  logic [N_REQ-1:0] w_elig;

  always_comb begin
    w_elig = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_elig[i] = i_req[i] && (i_req_msg[i*MSG_W +: MSG_W] <= LP_MSG_MAX);
    end
  end

  // Scan from the lowest priority up so the lowest eligible index is the
  // last assignment and therefore the winner.
  always_comb begin
    o_any    = 1'b0;
    o_idx    = '0;
    o_onehot = '0;
    o_code   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        o_any       = 1'b1;
        o_idx       = IDX_W'(i);
        o_onehot    = '0;
        o_onehot[i] = 1'b1;
        o_code      = i_req_msg[i*MSG_W +: MSG_W];
      end
    end
  end

endmodule

// File: rtl/lcd_msg_scheduler.sv
// lcd_msg_scheduler
//   Shares the 2x16 LCD message selector between several requesters. Picks a
//   message by fixed priority, waits for the LCD writer to be idle, commits the
//   code and holds it for at least HOLD_CYC cycles. Reverts to IDLE_MSG when
//   nobody requests.
//   Ports:
//     iCLK    system clock
//     iRST_N  asynchronous active-low reset
//     bus     scheduler side (slave) of lcd_msg_scheduler_if
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   S_IDLE | idle message shown, no eligible request
//   S_ARB  | one cycle: snapshot winner (or idle message) and its owner
//   S_WAIT | snapshot differs from oMSG; wait for iLCD_READY to commit
//   S_HOLD | minimum display time running; only higher priority preempts
module lcd_msg_scheduler
  import lcd_msg_scheduler_pkg::*;
#(
  parameter int               N_REQ    = N_REQ_DEF,
  parameter int               MSG_W    = MSG_W_DEF,
  parameter int               MSG_MAX  = MSG_MAX_DEF,
  parameter logic [MSG_W-1:0] IDLE_MSG = MSG_W'(MSG_INICIO),
  parameter int               HOLD_CYC = HOLD_CYC_DEF,
  parameter int               CNT_W    = CNT_W_DEF
) (
  input logic                 iCLK,
  input logic                 iRST_N,
  lcd_msg_scheduler_if.slave  bus
);

  localparam int               IDX_W     = idx_w(N_REQ);
  localparam logic [CNT_W-1:0] LP_RELOAD = CNT_W'(HOLD_CYC - 1);

  state_t           r_state;
  logic [MSG_W-1:0] r_msg;
  logic             r_stb;
  logic [N_REQ-1:0] r_grant;
  logic [CNT_W-1:0] r_cnt;
  logic [MSG_W-1:0] r_code;
  logic             r_own_vld;
  logic [IDX_W-1:0] r_own_idx;
  logic [N_REQ-1:0] r_own_oh;

  state_t           w_state_nxt;
  logic [MSG_W-1:0] w_msg_nxt;
  logic             w_stb_nxt;
  logic [N_REQ-1:0] w_grant_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [MSG_W-1:0] w_code_nxt;
  logic             w_own_vld_nxt;
  logic [IDX_W-1:0] w_own_idx_nxt;
  logic [N_REQ-1:0] w_own_oh_nxt;

  logic             w_any;
  logic [IDX_W-1:0] w_win_idx;
  logic [N_REQ-1:0] w_win_oh;
  logic [MSG_W-1:0] w_win_code;
  logic [MSG_W-1:0] w_arb_code;
  logic [N_REQ-1:0] w_arb_oh;
  logic             w_preempt;

  lcd_prio_arbiter #(
    .N_REQ   (N_REQ),
    .MSG_W   (MSG_W),
    .MSG_MAX (MSG_MAX),
    .IDX_W   (IDX_W)
  ) u_arb (
    .i_req     (bus.iREQ),
    .i_req_msg (bus.iREQ_MSG),
    .o_any     (w_any),
    .o_idx     (w_win_idx),
    .o_onehot  (w_win_oh),
    .o_code    (w_win_code)
  );

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state   <= S_IDLE;
      r_msg     <= IDLE_MSG;
      r_stb     <= 1'b0;
      r_grant   <= '0;
      r_cnt     <= '0;
      r_code    <= IDLE_MSG;
      r_own_vld <= 1'b0;
      r_own_idx <= '0;
      r_own_oh  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_msg     <= w_msg_nxt;
      r_stb     <= w_stb_nxt;
      r_grant   <= w_grant_nxt;
      r_cnt     <= w_cnt_nxt;
      r_code    <= w_code_nxt;
      r_own_vld <= w_own_vld_nxt;
      r_own_idx <= w_own_idx_nxt;
      r_own_oh  <= w_own_oh_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_msg_nxt     = r_msg;
    w_stb_nxt     = 1'b0;
    w_grant_nxt   = r_grant;
    w_cnt_nxt     = r_cnt;
    w_code_nxt    = r_code;
    w_own_vld_nxt = r_own_vld;
    w_own_idx_nxt = r_own_idx;
    w_own_oh_nxt  = r_own_oh;

    // With no eligible request the snapshot is the idle message, ownerless.
    w_arb_code = w_any ? w_win_code : IDLE_MSG;
    w_arb_oh   = w_any ? w_win_oh : '0;

    // An ownerless hold (idle message) yields to any eligible request.
    w_preempt = w_any && (!r_own_vld || (w_win_idx < r_own_idx));

    case (r_state)
      S_IDLE: begin
        w_grant_nxt = '0;
        if (w_any) w_state_nxt = S_ARB;
      end

      S_ARB: begin
        w_code_nxt    = w_arb_code;
        w_own_vld_nxt = w_any;
        w_own_idx_nxt = w_any ? w_win_idx : '0;
        w_own_oh_nxt  = w_arb_oh;
        if (w_arb_code == r_msg) begin
          // Already on screen: restart the hold without disturbing the LCD.
          w_grant_nxt = w_arb_oh;
          w_cnt_nxt   = LP_RELOAD;
          w_state_nxt = S_HOLD;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end

      S_WAIT: begin
        if (bus.iLCD_READY) begin
          w_msg_nxt   = r_code;
          w_grant_nxt = r_own_oh;
          w_stb_nxt   = 1'b1;
          w_cnt_nxt   = LP_RELOAD;
          w_state_nxt = S_HOLD;
        end
      end

      S_HOLD: begin
        if (w_preempt) begin
          w_state_nxt = S_ARB;
        end else if (r_cnt == '0) begin
          if (w_any || (r_msg != IDLE_MSG)) begin
            w_state_nxt = S_ARB;
          end else begin
            w_grant_nxt = '0;
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.oMSG     = r_msg;
  assign bus.oMSG_STB = r_stb;
  assign bus.oGRANT   = r_grant;
  assign bus.oBUSY    = (r_state != S_IDLE);

endmodule

// File: tb/tb_lcd_msg_scheduler.sv
// Directed bench for lcd_msg_scheduler with an 8-cycle hold.
module tb_lcd_msg_scheduler;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_stb;

  lcd_msg_scheduler_if #(.N_REQ(4), .MSG_W(3)) bus ();

  lcd_msg_scheduler #(
    .N_REQ    (4),
    .MSG_W    (3),
    .MSG_MAX  (5),
    .IDLE_MSG (3'd0),
    .HOLD_CYC (8),
    .CNT_W    (4)
  ) dut (
    .iCLK   (clk),
    .iRST_N (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic run_count(input int n, output int stb);
    stb = 0;
    repeat (n) begin
      tick();
      stb += int'(bus.oMSG_STB);
    end
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    bus.iREQ       = '0;
    bus.iREQ_MSG   = '0;
    bus.iLCD_READY = 1'b1;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    bus.iREQ       = '0;
    bus.iREQ_MSG   = '0;
    bus.iLCD_READY = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_msg",   32'(bus.oMSG),     32'd0);
    chk("rst_grant", 32'(bus.oGRANT),   32'd0);
    chk("rst_busy",  32'(bus.oBUSY),    32'd0);
    chk("rst_stb",   32'(bus.oMSG_STB), 32'd0);
    tick();
    rst_n = 1'b1;

    // Single request: req 2 code 4, commit after two more edges.
    bus.iREQ     = 4'b0100;
    bus.iREQ_MSG = {3'd0, 3'd4, 3'd0, 3'd0};
    tick();
    chk("s2_arb_busy", 32'(bus.oBUSY),    32'd1);
    chk("s2_arb_msg",  32'(bus.oMSG),     32'd0);
    chk("s2_arb_stb",  32'(bus.oMSG_STB), 32'd0);
    tick();
    chk("s2_wait_msg", 32'(bus.oMSG), 32'd0);
    tick();
    chk("s2_msg",   32'(bus.oMSG),     32'd4);
    chk("s2_stb",   32'(bus.oMSG_STB), 32'd1);
    chk("s2_grant", 32'(bus.oGRANT),   32'b0100);
    bus.iREQ = 4'b0000;
    run_count(7, n_stb);
    chk("s2_hold_stb",  32'(n_stb),    32'd0);
    chk("s2_hold_msg",  32'(bus.oMSG), 32'd4);
    chk("s2_hold_busy", 32'(bus.oBUSY), 32'd1);
    tick(2);
    chk("s2_revert_pending", 32'(bus.oMSG), 32'd4);
    tick();
    chk("s2_idle_msg",   32'(bus.oMSG),     32'd0);
    chk("s2_idle_stb",   32'(bus.oMSG_STB), 32'd1);
    chk("s2_idle_grant", 32'(bus.oGRANT),   32'd0);
    run_count(8, n_stb);
    chk("s2_end_stb",  32'(n_stb),     32'd0);
    chk("s2_end_busy", 32'(bus.oBUSY), 32'd0);

    // Reset in the middle of a hold.
    bus.iREQ     = 4'b0100;
    bus.iREQ_MSG = {3'd0, 3'd4, 3'd0, 3'd0};
    tick(3);
    chk("s1_commit_msg", 32'(bus.oMSG), 32'd4);
    tick(3);
    #2 rst_n = 1'b0;
    #1;
    chk("s1_msg",   32'(bus.oMSG),     32'd0);
    chk("s1_grant", 32'(bus.oGRANT),   32'd0);
    chk("s1_busy",  32'(bus.oBUSY),    32'd0);
    chk("s1_stb",   32'(bus.oMSG_STB), 32'd0);
    bus.iREQ = 4'b0000;
    #1 rst_n = 1'b1;
    run_count(3, n_stb);
    chk("s1_after_stb",  32'(n_stb),     32'd0);
    chk("s1_after_busy", 32'(bus.oBUSY), 32'd0);

    // Simultaneous requests: req 1 (code 3) wins, req 3 (code 5) after.
    bus.iREQ     = 4'b1010;
    bus.iREQ_MSG = {3'd5, 3'd0, 3'd3, 3'd0};
    tick(3);
    chk("s3_first_msg",   32'(bus.oMSG),   32'd3);
    chk("s3_first_grant", 32'(bus.oGRANT), 32'b0010);
    tick(2);
    bus.iREQ = 4'b1000;
    run_count(7, n_stb);
    chk("s3_hold_stb", 32'(n_stb),    32'd0);
    chk("s3_hold_msg", 32'(bus.oMSG), 32'd3);
    tick();
    chk("s3_second_msg",   32'(bus.oMSG),     32'd5);
    chk("s3_second_grant", 32'(bus.oGRANT),   32'b1000);
    chk("s3_second_stb",   32'(bus.oMSG_STB), 32'd1);

    // Req 2 (code 1) preempts the lower-priority owner req 3 at once.
    bus.iREQ     = 4'b0100;
    bus.iREQ_MSG = {3'd0, 3'd1, 3'd0, 3'd0};
    tick(3);
    chk("s4_own_msg",   32'(bus.oMSG),   32'd1);
    chk("s4_own_grant", 32'(bus.oGRANT), 32'b0100);
    tick(2);
    // Req 0 (code 5) on hold cycle 2.
    bus.iREQ     = 4'b0101;
    bus.iREQ_MSG = {3'd0, 3'd1, 3'd0, 3'd5};
    tick();
    chk("s4_arb_msg", 32'(bus.oMSG),     32'd1);
    chk("s4_arb_stb", 32'(bus.oMSG_STB), 32'd0);
    tick();
    chk("s4_wait_msg", 32'(bus.oMSG), 32'd1);
    tick();
    chk("s4_pre_msg",   32'(bus.oMSG),     32'd5);
    chk("s4_pre_grant", 32'(bus.oGRANT),   32'b0001);
    chk("s4_pre_stb",   32'(bus.oMSG_STB), 32'd1);
    // Lower priority req 2 waits out the full hold.
    bus.iREQ     = 4'b0100;
    bus.iREQ_MSG = {3'd0, 3'd1, 3'd0, 3'd0};
    run_count(9, n_stb);
    chk("s4_nopre_stb", 32'(n_stb),    32'd0);
    chk("s4_nopre_msg", 32'(bus.oMSG), 32'd5);
    tick();
    chk("s4_exp_msg",   32'(bus.oMSG),   32'd1);
    chk("s4_exp_grant", 32'(bus.oGRANT), 32'b0100);
    tick(2);
    // Req 3 joins; it never preempts req 2.
    bus.iREQ     = 4'b1100;
    bus.iREQ_MSG = {3'd2, 3'd1, 3'd0, 3'd0};
    run_count(12, n_stb);
    chk("s4_r3_stb",   32'(n_stb),      32'd0);
    chk("s4_r3_msg",   32'(bus.oMSG),   32'd1);
    chk("s4_r3_grant", 32'(bus.oGRANT), 32'b0100);

    // LCD writer busy for 20 cycles after ARB.
    do_reset();
    bus.iLCD_READY = 1'b0;
    bus.iREQ       = 4'b0001;
    bus.iREQ_MSG   = {3'd0, 3'd0, 3'd0, 3'd4};
    tick(2);
    run_count(20, n_stb);
    chk("s5_wait_stb",  32'(n_stb),     32'd0);
    chk("s5_wait_msg",  32'(bus.oMSG),  32'd0);
    chk("s5_wait_busy", 32'(bus.oBUSY), 32'd1);
    bus.iLCD_READY = 1'b1;
    tick();
    chk("s5_msg",   32'(bus.oMSG),     32'd4);
    chk("s5_stb",   32'(bus.oMSG_STB), 32'd1);
    chk("s5_grant", 32'(bus.oGRANT),   32'b0001);
    tick();
    chk("s5_stb_once", 32'(bus.oMSG_STB), 32'd0);

    // Invalid codes are ignored.
    do_reset();
    bus.iREQ     = 4'b0001;
    bus.iREQ_MSG = {3'd0, 3'd0, 3'd0, 3'd6};
    run_count(3, n_stb);
    chk("s6_c6_busy", 32'(bus.oBUSY), 32'd0);
    chk("s6_c6_msg",  32'(bus.oMSG),  32'd0);
    bus.iREQ_MSG = {3'd0, 3'd0, 3'd0, 3'd7};
    run_count(3, n_stb);
    chk("s6_c7_busy", 32'(bus.oBUSY), 32'd0);
    chk("s6_c7_stb",  32'(n_stb),     32'd0);
    // Owner keeps code 2 past several expiries: no extra strobes.
    bus.iREQ_MSG = {3'd0, 3'd0, 3'd0, 3'd2};
    tick(3);
    chk("s6_msg", 32'(bus.oMSG),     32'd2);
    chk("s6_stb", 32'(bus.oMSG_STB), 32'd1);
    run_count(20, n_stb);
    chk("s6_keep_stb",   32'(n_stb),      32'd0);
    chk("s6_keep_msg",   32'(bus.oMSG),   32'd2);
    chk("s6_keep_grant", 32'(bus.oGRANT), 32'b0001);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
